// File: rtl/seg7_capture.sv
// seg7_capture: debounces a multiplexed 4-digit seven-segment scan and recovers the BCD digit per position.
module seg7_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig_sel,
  output logic [15:0] bcd_out,
  output logic [3:0]  digit_valid,
  output logic [3:0]  digit_err,
  output logic        update,
  output logic [1:0]  upd_idx,
  output logic        frame_done
);
  localparam logic [7:0] SC = 8'(STABLE_CYCLES);
  logic [10:0] held;
  logic [7:0]  cnt;
  logic [3:0]  seen, seen_or, sel, val;
  logic [1:0]  idx;
  logic        fresh, cap, legal, onehot;
  assign sel     = held[10:7];
  assign onehot  = sel != 4'd0 && (sel & (sel - 4'd1)) == 4'd0;
  assign idx     = {sel[3] | sel[2], sel[3] | sel[1]};
  assign seen_or = seen | (4'b1 << idx);
  // cnt is only zero straight after reset, so the first sample is always treated as new
  assign fresh   = {dig_sel, seg} != held || cnt == 8'd0;
  assign cap     = !fresh && cnt == SC - 8'd1 && onehot;
  always_comb begin
    val   = 4'hF;
    legal = 1'b1;
    case (held[6:0])
      7'b1111110: val = 4'd0;
      7'b0110000: val = 4'd1;
      7'b1101101: val = 4'd2;
      7'b1111001: val = 4'd3;
      7'b0110011: val = 4'd4;
      7'b1011011: val = 4'd5;
      7'b1011111: val = 4'd6;
      7'b1110000: val = 4'd7;
      7'b1111111: val = 4'd8;
      7'b1111011: val = 4'd9;
      default:    legal = 1'b0;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held        <= '0;
      cnt         <= '0;
      seen        <= '0;
      bcd_out     <= 16'hFFFF;
      digit_valid <= '0;
      digit_err   <= '0;
      update      <= 1'b0;
      upd_idx     <= '0;
      frame_done  <= 1'b0;
    end else begin
      held       <= {dig_sel, seg};
      cnt        <= fresh ? 8'd1 : cnt == SC ? cnt : cnt + 8'd1;
      update     <= cap;
      frame_done <= cap && seen_or == 4'hF;
      if (cap) begin
        upd_idx                   <= idx;
        bcd_out[{idx, 2'b00} +: 4] <= val;
        digit_err[idx]            <= !legal;
        digit_valid[idx]          <= 1'b1;
        seen                      <= seen_or == 4'hF ? 4'd0 : seen_or;
      end
    end
  end
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: randomized scoreboard bench for seg7_capture against a run-length reference model.
module tb_seg7_capture;
  localparam int SC = 4;
  typedef struct {
    logic [1:0]  idx;
    logic        fd;
    logic [15:0] bcd;
    logic [3:0]  v;
    logic [3:0]  e;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0]  seg = '0;
  logic [3:0]  dig_sel = '0;
  logic [15:0] bcd_out;
  logic [3:0]  digit_valid, digit_err;
  logic        update, frame_done;
  logic [1:0]  upd_idx;
  int tests = 0, fails = 0, n_exp = 0, n_upd = 0;
  exp_t q[$];
  logic [6:0]  pats [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                             7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
  logic [10:0] m_prev;
  int          m_run = 0;
  logic [15:0] m_bcd = 16'hFFFF;
  logic [3:0]  m_v = '0, m_e = '0, m_seen = '0;

  seg7_capture #(.STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .seg(seg), .dig_sel(dig_sel), .bcd_out(bcd_out),
    .digit_valid(digit_valid), .digit_err(digit_err), .update(update),
    .upd_idx(upd_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic void dec(input logic [6:0] s, output logic [3:0] v, output logic ok);
    v = 4'hF;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) if (pats[i] == s) begin v = 4'(i); ok = 1'b1; end
  endfunction

  // One clock with the given inputs; the model decides whether this edge completes a stable run.
  task automatic step(input logic [3:0] d, input logic [6:0] s);
    exp_t x;
    logic [3:0] v;
    logic ok;
    int i;
    dig_sel = d;
    seg = s;
    @(posedge clk);
    if (m_run > 0 && {d, s} == m_prev) m_run++;
    else begin m_run = 1; m_prev = {d, s}; end
    if (m_run == SC && $countones(d) == 1) begin
      i = 0;
      for (int k = 0; k < 4; k++) if (d[k]) i = k;
      dec(s, v, ok);
      m_bcd[i*4 +: 4] = v;
      m_e[i] = !ok;
      m_v[i] = 1'b1;
      m_seen[i] = 1'b1;
      x.fd = m_seen == 4'hF;
      if (x.fd) m_seen = '0;
      x.idx = 2'(i);
      x.bcd = m_bcd;
      x.v = m_v;
      x.e = m_e;
      q.push_back(x);
      n_exp++;
    end
    @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) step(d, s);
  endtask

  task automatic model_reset();
    m_run = 0;
    m_bcd = 16'hFFFF;
    m_v = '0;
    m_e = '0;
    m_seen = '0;
    q.delete();
  endtask

  task automatic rst_checks();
    chk("rst_bcd", bcd_out, 16'hFFFF);
    chk("rst_valid", 16'(digit_valid), 16'd0);
    chk("rst_err", 16'(digit_err), 16'd0);
    chk("rst_pulses", 16'({update, upd_idx, frame_done}), 16'd0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 rst_checks();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (update) begin
          n_upd++;
          tests++;
          if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_update idx=%0d bcd=%h", upd_idx, bcd_out);
          end else begin
            x = q.pop_front();
            if (upd_idx !== x.idx || frame_done !== x.fd || bcd_out !== x.bcd ||
                digit_valid !== x.v || digit_err !== x.e) begin
              fails++;
              $display("FAIL capture got idx=%0d fd=%b bcd=%h v=%b e=%b want idx=%0d fd=%b bcd=%h v=%b e=%b",
                       upd_idx, frame_done, bcd_out, digit_valid, digit_err, x.idx, x.fd, x.bcd, x.v, x.e);
            end
          end
        end else if (q.size() != 0) begin
          x = q.pop_front();
          tests++;
          fails++;
          $display("FAIL missing_update got update=0 want idx=%0d bcd=%h", x.idx, x.bcd);
        end
        if (frame_done && !update) begin
          tests++;
          fails++;
          $display("FAIL stray_frame_done got fd=1 want fd=0");
        end
      end
    end
  end

  initial begin
    logic [3:0] d;
    logic [6:0] s;
    int r;
    repeat (2) @(negedge clk);
    rst_checks();
    rst = 1'b0;
    hold(4'b0001, 7'b1111001, 4);
    chk("t1_digit0", 16'(bcd_out[3:0]), 16'd3);
    chk("t1_pulse", 16'({update, upd_idx, frame_done}), 16'b1000);
    hold(4'b0001, 7'b0110000, 6); hold(4'b0000, 7'b0, 1);
    hold(4'b0010, 7'b1101101, 6); hold(4'b0000, 7'b0, 1);
    hold(4'b0100, 7'b1011011, 6); hold(4'b0000, 7'b0, 1);
    hold(4'b1000, 7'b1111011, 6); hold(4'b0000, 7'b0, 1);
    chk("t2_scan", bcd_out, 16'h9521);
    hold(4'b0010, 7'b0110011, 3);
    hold(4'b0000, 7'b0, 1);
    chk("t3_short", 16'(bcd_out[7:4]), 16'd2);
    hold(4'b0010, 7'b0110011, 4);
    chk("t3_digit1", 16'(bcd_out[7:4]), 16'd4);
    hold(4'b0100, 7'b0000000, 4);
    chk("t4_blank", 16'({bcd_out[11:8], digit_err}), 16'hF4);
    hold(4'b0100, 7'b1110000, 4);
    chk("t4_seven", 16'({bcd_out[11:8], digit_err}), 16'h70);
    hold(4'b0011, 7'b1111111, 10);
    chk("t5_ghost", bcd_out, 16'h9741);
    hold(4'b0001, 7'b1111110, 20);
    hold(4'b0001, 7'b1111001, 4); hold(4'b0010, 7'b1101101, 4); hold(4'b0100, 7'b1011011, 4);
    hold(4'b1000, 7'b1111011, 2);
    do_reset();
    hold(4'b1000, 7'b1111011, 4); hold(4'b0100, 7'b1011011, 4); hold(4'b0010, 7'b1101101, 4);
    chk("t6_partial", 16'(digit_valid), 16'b1110);
    hold(4'b0001, 7'b0110000, 4);
    chk("t6_frame", 16'({frame_done, bcd_out[3:0]}), 16'h11);
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      d = r < 6 ? 4'b1 << $urandom_range(0, 3) : r == 6 ? 4'b0 : 4'($urandom);
      s = $urandom_range(0, 9) < 7 ? pats[$urandom_range(0, 9)] : 7'($urandom);
      if ($urandom_range(0, 59) == 0) do_reset();
      hold(d, s, $urandom_range(1, 7));
    end
    hold(4'b0000, 7'b0, 3);
    chk("queue_drained", 16'(q.size()), 16'd0);
    chk("update_count", 16'(n_upd), 16'(n_exp));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
